lsu_mem_ctrl: RTL and testbench

//  Sequences load/store accesses from the core's LSU onto a variable-latency data-memory bus.

---
 rtl/lsu_mem_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the LSU and a req/gnt/rvalid data-memory bus.
// Checks legality and alignment, steers byte lanes, formats load data and stalls the core.
//
//  state   | meaning
//  IDLE    | no access in flight; accepts req_i
//  REQ     | bus request asserted, waiting for grant
//  WAIT    | load granted, waiting for read data
//  RESP    | one-cycle done pulse, access succeeded
//  FAULT   | one-cycle done pulse with error code, no bus activity
module lsu_mem_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_FAULT
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT > 0);

    localparam logic [1:0] ERR_MISAL = 2'b01;
    localparam logic [1:0] ERR_ILL   = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          req_illegal;
    logic          req_misal;
    logic          tmo_hit;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_fmt;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;

    // Legality and alignment are judged on the live request so a fault costs one cycle.
    always_comb begin
        req_illegal = 1'b0;
        req_misal   = 1'b0;
        if (we_i) begin
            req_illegal = (funct3_i[2] == 1'b1) || (funct3_i[1:0] == 2'b11);
        end else begin
            req_illegal = (funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110);
        end
        case (funct3_i[1:0])
            2'b01:   req_misal = addr_i[0];
            2'b10:   req_misal = (addr_i[1:0] != 2'b00);
            default: req_misal = 1'b0;
        endcase
    end

    always_comb begin
        lane_b   = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        load_fmt = mem_rdata_i;
        case (f3_q)
            3'b000:  load_fmt = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_fmt = {24'h000000, lane_b};
            3'b001:  load_fmt = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_fmt = {16'h0000, lane_h};
            default: load_fmt = mem_rdata_i;
        endcase
    end

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << addr_q[1:0];
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    // Counter saturates at terminal count so a late grant leaves no budget for WAIT.
    always_comb begin
        tmo_hit = TMO_EN && (cnt_q == TC);
        cnt_inc = (cnt_q == TC) ? cnt_q : cnt_q + CW'(1);
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    f3_d    = funct3_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    if (req_illegal) begin
                        err_d   = ERR_ILL;
                        rdata_d = 32'h0;
                        state_d = S_FAULT;
                    end else if (req_misal) begin
                        err_d   = ERR_MISAL;
                        rdata_d = 32'h0;
                        state_d = S_FAULT;
                    end else begin
                        err_d   = 2'b00;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    cnt_d   = cnt_inc;
                    state_d = we_q ? S_RESP : S_WAIT;
                end else if (tmo_hit) begin
                    err_d   = ERR_TMO;
                    rdata_d = 32'h0;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    rdata_d = load_fmt;
                    state_d = S_RESP;
                end else if (tmo_hit) begin
                    err_d   = ERR_TMO;
                    rdata_d = 32'h0;
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 2'b00;
            rdata_q <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_RESP) || (state_q == S_FAULT);
        err_o       = (state_q == S_FAULT) ? err_q : 2'b00;
        rdata_o     = rdata_q;
        mem_req_o   = (state_q == S_REQ);
        mem_we_o    = (state_q == S_REQ) && we_q;
        mem_be_o    = (state_q == S_REQ) ? be : 4'b0000;
        mem_addr_o  = (state_q == S_REQ) ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_wdata_o = (state_q == S_REQ) ? wdata_rep : 32'h0;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed scenarios plus random transactions against
// a transaction-level model of lane steering, load formatting and error codes.
module tb_lsu_mem_ctrl;

    localparam int TIMEOUT = 64;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        req_i;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    lsu_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rdata_hold = 32'h0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [1:0] model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 2'b10;
        if ((int'(addr[1:0]) % access_size(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int mask;
        mask = ((1 << access_size(f3)) - 1) << int'(addr[1:0]);
        return 4'(mask);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sz;
        sz = access_size(f3);
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % sz)*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] raw);
        logic [31:0] v;
        int bits;
        bits = 8 * access_size(f3);
        v = raw >> (8 * int'(addr[1:0]));
        if (bits < 32) begin
            v = v & ((32'h1 << bits) - 32'h1);
            if (!f3[2] && v[bits-1]) v = v | ~((32'h1 << bits) - 32'h1);
        end
        return v;
    endfunction

    task automatic run_txn(input string tag, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int gnt_dly, input int rv_dly, input logic [31:0] raw);
        logic [1:0] e;
        e = model_err(we, f3, addr);
        check({tag, " idle_busy"}, 32'(busy_o), 32'h0);
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'($urandom); funct3_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom;
        check({tag, " busy"}, 32'(busy_o), 32'h1);
        if (e != 2'b00) begin
            check({tag, " fault_done"}, 32'(done_o), 32'h1);
            check({tag, " fault_err"}, 32'(err_o), 32'(e));
            check({tag, " fault_rdata"}, rdata_o, 32'h0);
            check({tag, " fault_noreq"}, 32'(mem_req_o), 32'h0);
            rdata_hold = 32'h0;
            @(negedge clk_i);
            check({tag, " fault_after"}, {30'h0, busy_o, done_o}, 32'h0);
            return;
        end
        for (int k = 0; k <= gnt_dly; k++) begin
            check({tag, " req"}, {27'h0, mem_req_o, mem_we_o, busy_o, done_o, 1'b0}, {27'h0, 1'b1, we, 1'b1, 1'b0, 1'b0});
            check({tag, " be"}, 32'(mem_be_o), 32'(model_be(f3, addr)));
            check({tag, " addr"}, mem_addr_o, {addr[31:2], 2'b00});
            if (we) check({tag, " wdata"}, mem_wdata_o, model_wdata(f3, wd));
            mem_gnt_i = (k == gnt_dly);
            mem_rvalid_i = 1'($urandom);
            @(negedge clk_i);
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        check({tag, " req_drop"}, 32'(mem_req_o), 32'h0);
        if (!we) begin
            for (int j = 0; j <= rv_dly; j++) begin
                check({tag, " wait"}, {29'h0, mem_req_o, busy_o, done_o}, 32'h2);
                mem_gnt_i = 1'($urandom);
                mem_rvalid_i = (j == rv_dly);
                mem_rdata_i = (j == rv_dly) ? raw : $urandom;
                @(negedge clk_i);
            end
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            rdata_hold = model_load(f3, addr, raw);
        end
        check({tag, " done"}, {30'h0, busy_o, done_o}, 32'h3);
        check({tag, " err"}, 32'(err_o), 32'h0);
        check({tag, " rdata"}, rdata_o, rdata_hold);
        @(negedge clk_i);
        check({tag, " after"}, {30'h0, busy_o, done_o}, 32'h0);
        check({tag, " rdata_hold"}, rdata_o, rdata_hold);
    endtask

    initial begin
        int n;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n_i = 1'b0; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b0; addr_i = 32'h0; wdata_i = 32'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        repeat (3) @(negedge clk_i);
        check("reset_ctl", {25'h0, busy_o, done_o, err_o, mem_req_o, mem_we_o, 1'b0}, 32'h0);
        check("reset_bus", {mem_addr_o | mem_wdata_o | rdata_o}, 32'h0);
        check("reset_be", 32'(mem_be_o), 32'h0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        run_txn("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        run_txn("sb", 1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 0, 32'h0);
        run_txn("sh", 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 2, 0, 32'h0);
        run_txn("lh_misal", 1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0);
        run_txn("ld_ill", 1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
        run_txn("st_ill", 1'b1, 3'b100, 32'h101, 32'h0, 0, 0, 32'h0);

        // Grant never arrives: request must be withdrawn after exactly TIMEOUT cycles.
        req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h200;
        @(negedge clk_i);
        req_i = 1'b0;
        n = 0;
        while (mem_req_o === 1'b1 && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        check("tmo_req_cycles", n, TIMEOUT);
        check("tmo_done", {30'h0, busy_o, done_o}, 32'h3);
        check("tmo_err", 32'(err_o), 32'h3);
        check("tmo_rdata", rdata_o, 32'h0);
        rdata_hold = 32'h0;
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        check("tmo_late_gnt", {29'h0, mem_req_o, busy_o, done_o}, 32'h0);
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        check("tmo_idle", {29'h0, mem_req_o, busy_o, done_o}, 32'h0);

        run_txn("lb", 1'b0, 3'b000, 32'h102, 32'h0, 0, 2, 32'h12803456);
        run_txn("lbu", 1'b0, 3'b100, 32'h102, 32'h0, 0, 2, 32'h12803456);

        // Reset in WAIT: no completion, late rvalid ignored.
        req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h300;
        @(negedge clk_i);
        req_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        check("rst_wait_ctl", {25'h0, busy_o, done_o, err_o, mem_req_o, mem_we_o, 1'b0}, 32'h0);
        check("rst_wait_rdata", rdata_o, 32'h0);
        rdata_hold = 32'h0;
        rst_n_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        check("rst_late_rvalid", {29'h0, mem_req_o, busy_o, done_o}, 32'h0);
        check("rst_late_rdata", rdata_o, 32'h0);
        run_txn("lw_after_rst", 1'b0, 3'b010, 32'h400, 32'h0, 1, 1, 32'hCAFEF00D);

        for (int t = 0; t < 150; t++) begin
            run_txn("rnd", 1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
